// File: rtl/my_sync_fifo.sv
// my_sync_fifo: single-clock FIFO with inferred storage, optional
// first-word-fall-through read port, programmable almost-full/almost-empty
// levels and an occupancy count.
//
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   clr          synchronous flush, overrides wr_en/rd_en
//   din          write data (WIDTH bits)
//   wr_en        write request
//   rd_en        read request (standard) / pop request (FWFT)
//   dout         read data (registered)
//   full         count == DEPTH
//   empty        no readable word
//   almostfull   count >= AFULL_LEVEL
//   almostempty  count <= AEMPTY_LEVEL
//   count        words written and not yet popped (0..DEPTH)
//   wrerr        one-cycle pulse after a rejected write
//   rderr        one-cycle pulse after a rejected read
//
// Every output is a flop; nothing combinational reaches an output from
// wr_en, rd_en or din.

module my_sync_fifo #(
    parameter int WIDTH        = 9,
    parameter int DEPTH        = 512,
    parameter int AFULL_LEVEL  = DEPTH - 4,
    parameter int AEMPTY_LEVEL = 4,
    parameter int FWFT         = 0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almostfull,
    output logic                     almostempty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wrerr,
    output logic                     rderr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Parameter legality is checked at elaboration.
    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("my_sync_fifo: WIDTH must be 1..64");
        end
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("my_sync_fifo: DEPTH must be a power of two >= 4");
        end
        if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
            $error("my_sync_fifo: AFULL_LEVEL must be 1..DEPTH");
        end
        if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
            $error("my_sync_fifo: AEMPTY_LEVEL must be 0..DEPTH-1");
        end
        if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
            $error("my_sync_fifo: FWFT must be 0 or 1");
        end
    endgenerate

    logic [WIDTH-1:0] mem_r [DEPTH];

    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] dout_r;
    logic             full_r;
    logic             empty_r;
    logic             afull_r;
    logic             aempty_r;
    logic             wrerr_r;
    logic             rderr_r;
    logic             valid_r;      // FWFT prefetch register holds the head word

    logic             wr_acc_s;
    logic             rd_acc_s;
    logic             ram_has_s;
    logic             ram_rd_s;
    logic             valid_next_s;
    logic [CW-1:0]    count_next_s;
    logic             empty_next_s;

    // Request acceptance, RAM read strobe and next-state occupancy/flags.
    always_comb begin
        wr_acc_s  = wr_en && !full_r;
        rd_acc_s  = rd_en && !empty_r;
        // Words sitting in RAM, i.e. not yet moved into the prefetch register.
        ram_has_s = (count_r > {{(CW-1){1'b0}}, valid_r});

        if (FWFT != 0) begin
            // Refill the prefetch register whenever it is free or being popped.
            ram_rd_s = (!valid_r || rd_acc_s) && ram_has_s;
            if (ram_rd_s) begin
                valid_next_s = 1'b1;
            end else if (rd_acc_s) begin
                valid_next_s = 1'b0;
            end else begin
                valid_next_s = valid_r;
            end
        end else begin
            ram_rd_s     = rd_acc_s;
            valid_next_s = 1'b0;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + CW'(1'b1);
            2'b01:   count_next_s = count_r - CW'(1'b1);
            default: count_next_s = count_r;
        endcase

        if (FWFT != 0) begin
            empty_next_s = !valid_next_s;
        end else begin
            empty_next_s = (count_next_s == {CW{1'b0}});
        end
    end

    // Storage array: no reset so it can map onto RAM; contents are
    // meaningless after reset or flush because the pointers restart.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !clr) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy, read data, flags and error pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            dout_r   <= {WIDTH{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
            wrerr_r  <= 1'b0;
            rderr_r  <= 1'b0;
            valid_r  <= 1'b0;
        end else if (clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            dout_r   <= {WIDTH{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
            wrerr_r  <= 1'b0;
            rderr_r  <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (ram_rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
                dout_r   <= mem_r[rd_ptr_r];
            end
            count_r  <= count_next_s;
            valid_r  <= valid_next_s;
            full_r   <= (count_next_s == CW'(DEPTH));
            empty_r  <= empty_next_s;
            afull_r  <= (count_next_s >= CW'(AFULL_LEVEL));
            aempty_r <= (count_next_s <= CW'(AEMPTY_LEVEL));
            wrerr_r  <= wr_en && full_r;
            rderr_r  <= rd_en && empty_r;
        end
    end

    assign dout        = dout_r;
    assign full        = full_r;
    assign empty       = empty_r;
    assign almostfull  = afull_r;
    assign almostempty = aempty_r;
    assign count       = count_r;
    assign wrerr       = wrerr_r;
    assign rderr       = rderr_r;

endmodule

// File: tb/tb_my_sync_fifo.sv
// Bench for my_sync_fifo: one standard-mode and one FWFT instance with the
// default 9x512 geometry, checked every cycle against a queue-based model.
module tb_my_sync_fifo;

    localparam int DEPTH = 512;
    localparam int AFL   = DEPTH - 4;
    localparam int AEL   = 4;

    typedef struct packed {
        logic [8:0] d;
        int         we;     // index of the edge that wrote the word
    } word_t;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       clr;
        logic [8:0] din;
        int         cnt;
        logic       full;
        logic       empty;
        logic [8:0] dout;
        logic       werr;
        logic       rerr;
    } vec_t;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       wr    [2];
    logic       rd    [2];
    logic       clr_v [2];
    logic [8:0] din_v [2];
    logic [8:0] dout_o[2];
    logic       full_o[2];
    logic       empty_o[2];
    logic       af_o  [2];
    logic       ae_o  [2];
    logic       werr_o[2];
    logic       rerr_o[2];
    logic [9:0] cnt_o [2];

    word_t      mq[2][$];
    logic [8:0] mdout[2];
    logic       mwerr[2];
    logic       mrerr[2];
    int         edge_n = 0;
    int         tests  = 0;
    int         fails  = 0;

    always #5 clk = ~clk;

    my_sync_fifo #(.FWFT(0)) u_std (
        .clk(clk), .rstn(rstn), .clr(clr_v[0]), .din(din_v[0]),
        .wr_en(wr[0]), .rd_en(rd[0]), .dout(dout_o[0]), .full(full_o[0]),
        .empty(empty_o[0]), .almostfull(af_o[0]), .almostempty(ae_o[0]),
        .count(cnt_o[0]), .wrerr(werr_o[0]), .rderr(rerr_o[0]));

    my_sync_fifo #(.FWFT(1)) u_fwft (
        .clk(clk), .rstn(rstn), .clr(clr_v[1]), .din(din_v[1]),
        .wr_en(wr[1]), .rd_en(rd[1]), .dout(dout_o[1]), .full(full_o[1]),
        .empty(empty_o[1]), .almostfull(af_o[1]), .almostempty(ae_o[1]),
        .count(cnt_o[1]), .wrerr(werr_o[1]), .rderr(rerr_o[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Head word is readable after edge t. In FWFT a word written at edge W
    // is readable only from edge W+1 on.
    function automatic bit vis(input int m, input int t);
        if (mq[m].size() == 0) return 1'b0;
        if (m == 0) return 1'b1;
        return mq[m][0].we < t;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            mdout[m] = 9'h000;
            mwerr[m] = 1'b0;
            mrerr[m] = 1'b0;
        end
    endtask

    task automatic model_edge(input int m);
        bit    pre_full;
        bit    pre_empty;
        word_t w;
        pre_full  = (mq[m].size() == DEPTH);
        pre_empty = !vis(m, edge_n - 1);
        if (clr_v[m]) begin
            mq[m].delete();
            mdout[m] = 9'h000;
            mwerr[m] = 1'b0;
            mrerr[m] = 1'b0;
        end else begin
            mwerr[m] = wr[m] && pre_full;
            mrerr[m] = rd[m] && pre_empty;
            if (rd[m] && !pre_empty) begin
                w = mq[m].pop_front();
                if (m == 0) mdout[m] = w.d;
            end
            if (wr[m] && !pre_full) begin
                w.d  = din_v[m];
                w.we = edge_n;
                mq[m].push_back(w);
            end
            if (m == 1 && vis(1, edge_n)) mdout[1] = mq[1][0].d;
        end
    endtask

    task automatic compare(input int m);
        string p;
        int    n;
        bit    e;
        p = (m == 0) ? "std" : "fwft";
        n = mq[m].size();
        e = !vis(m, edge_n);
        chk({p, " count"},       64'(cnt_o[m]),   64'(n));
        chk({p, " full"},        64'(full_o[m]),  64'(n == DEPTH));
        chk({p, " empty"},       64'(empty_o[m]), 64'(e));
        chk({p, " almostfull"},  64'(af_o[m]),    64'(n >= AFL));
        chk({p, " almostempty"}, 64'(ae_o[m]),    64'(n <= AEL));
        chk({p, " wrerr"},       64'(werr_o[m]),  64'(mwerr[m]));
        chk({p, " rderr"},       64'(rerr_o[m]),  64'(mrerr[m]));
        if (m == 0 || !e) chk({p, " dout"}, 64'(dout_o[m]), 64'(mdout[m]));
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        for (int m = 0; m < 2; m++) model_edge(m);
        #1;
        for (int m = 0; m < 2; m++) compare(m);
    endtask

    task automatic drive(input int m, input logic w, input logic r, input logic c, input logic [8:0] d);
        wr[m]    = w;
        rd[m]    = r;
        clr_v[m] = c;
        din_v[m] = d;
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 1'b0, 9'h000);
        drive(1, 1'b0, 1'b0, 1'b0, 9'h000);
    endtask

    // Steer both FIFOs to the given occupancies with random data.
    task automatic goto_level(input int t0, input int t1);
        for (int k = 0; k < 3000; k++) begin
            if (mq[0].size() == t0 && mq[1].size() == t1) break;
            drive(0, mq[0].size() < t0, mq[0].size() > t0, 1'b0, 9'($urandom));
            drive(1, mq[1].size() < t1, mq[1].size() > t1, 1'b0, 9'($urandom));
            tick();
        end
        idle();
        chk("goto std count",  64'(cnt_o[0]), 64'(t0));
        chk("goto fwft count", 64'(cnt_o[1]), 64'(t1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[9];
        int   af_first;
        int   ae_first;
        int   ops;
        logic w0;
        logic r0;

        // wr rd clr din | cnt full empty dout werr rerr  (standard instance)
        tv[0] = '{1'b1, 1'b0, 1'b0, 9'h011, 1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b1, 1'b0, 9'h022, 1, 1'b0, 1'b0, 9'h011, 1'b0, 1'b0};
        tv[2] = '{1'b0, 1'b1, 1'b0, 9'h000, 0, 1'b0, 1'b1, 9'h022, 1'b0, 1'b0};
        tv[3] = '{1'b0, 1'b1, 1'b0, 9'h000, 0, 1'b0, 1'b1, 9'h022, 1'b0, 1'b1};
        tv[4] = '{1'b0, 1'b0, 1'b0, 9'h000, 0, 1'b0, 1'b1, 9'h022, 1'b0, 1'b0};
        tv[5] = '{1'b1, 1'b1, 1'b0, 9'h033, 1, 1'b0, 1'b0, 9'h022, 1'b0, 1'b1};
        tv[6] = '{1'b1, 1'b0, 1'b1, 9'h044, 0, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0};
        tv[7] = '{1'b0, 1'b1, 1'b0, 9'h000, 0, 1'b0, 1'b1, 9'h000, 1'b0, 1'b1};
        tv[8] = '{1'b0, 1'b0, 1'b0, 9'h000, 0, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0};

        idle();
        model_reset();
        #12;
        for (int m = 0; m < 2; m++) compare(m);
        rstn = 1'b1;

        // Directed vectors on the standard instance.
        for (int i = 0; i < 9; i++) begin
            drive(0, tv[i].wr, tv[i].rd, tv[i].clr, tv[i].din);
            drive(1, 1'b0, 1'b0, 1'b0, 9'h000);
            tick();
            chk($sformatf("vec%0d count", i), 64'(cnt_o[0]),   64'(tv[i].cnt));
            chk($sformatf("vec%0d full", i),  64'(full_o[0]),  64'(tv[i].full));
            chk($sformatf("vec%0d empty", i), 64'(empty_o[0]), 64'(tv[i].empty));
            chk($sformatf("vec%0d dout", i),  64'(dout_o[0]),  64'(tv[i].dout));
            chk($sformatf("vec%0d wrerr", i), 64'(werr_o[0]),  64'(tv[i].werr));
            chk($sformatf("vec%0d rderr", i), 64'(rerr_o[0]),  64'(tv[i].rerr));
        end

        // Fill the standard instance with 0x000..0x1FF.
        af_first = -1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1'b1, 1'b0, 1'b0, 9'(i));
            tick();
            if (af_o[0] && af_first < 0) af_first = int'(cnt_o[0]);
        end
        chk("fill afull first", 64'(af_first), 64'(AFL));
        chk("fill full", 64'(full_o[0]), 64'(1));
        chk("fill count", 64'(cnt_o[0]), 64'(DEPTH));
        drive(0, 1'b1, 1'b0, 1'b0, 9'h1AA);
        tick();
        chk("overflow wrerr", 64'(werr_o[0]), 64'(1));
        chk("overflow count", 64'(cnt_o[0]), 64'(DEPTH));
        idle();
        tick();
        chk("overflow wrerr drop", 64'(werr_o[0]), 64'(0));

        // Drain in order.
        ae_first = -1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1'b0, 1'b1, 1'b0, 9'h000);
            tick();
            chk("drain dout", 64'(dout_o[0]), 64'(i));
            if (ae_o[0] && ae_first < 0) ae_first = int'(cnt_o[0]);
        end
        chk("drain aempty first", 64'(ae_first), 64'(AEL));
        chk("drain empty", 64'(empty_o[0]), 64'(1));
        tick();
        chk("underflow rderr", 64'(rerr_o[0]), 64'(1));
        chk("underflow dout hold", 64'(dout_o[0]), 64'(9'h1FF));
        idle();
        tick();
        chk("underflow rderr drop", 64'(rerr_o[0]), 64'(0));

        // FWFT single word: visible two edges after the write.
        drive(1, 1'b1, 1'b0, 1'b0, 9'h1A5);
        tick();
        chk("fwft empty after E", 64'(empty_o[1]), 64'(1));
        idle();
        tick();
        chk("fwft empty after E+1", 64'(empty_o[1]), 64'(0));
        chk("fwft dout after E+1", 64'(dout_o[1]), 64'(9'h1A5));
        drive(1, 1'b0, 1'b1, 1'b0, 9'h000);
        tick();
        chk("fwft empty after pop", 64'(empty_o[1]), 64'(1));
        for (int i = 1; i <= 3; i++) begin
            drive(1, 1'b1, 1'b0, 1'b0, 9'(i));
            tick();
        end
        chk("fwft head 1", 64'(dout_o[1]), 64'(1));
        for (int i = 2; i <= 4; i++) begin
            drive(1, 1'b0, 1'b1, 1'b0, 9'h000);
            tick();
            if (i <= 3) begin
                chk("fwft b2b empty", 64'(empty_o[1]), 64'(0));
                chk("fwft b2b dout", 64'(dout_o[1]), 64'(i));
            end else begin
                chk("fwft b2b final empty", 64'(empty_o[1]), 64'(1));
            end
        end
        idle();

        // Simultaneous write+read at count 5, then at full and at empty.
        goto_level(5, 5);
        for (int k = 0; k < 10; k++) begin
            drive(0, 1'b1, 1'b1, 1'b0, 9'($urandom));
            drive(1, 1'b1, 1'b1, 1'b0, 9'($urandom));
            tick();
            chk("simul std count", 64'(cnt_o[0]), 64'(5));
            chk("simul fwft count", 64'(cnt_o[1]), 64'(5));
        end
        goto_level(DEPTH, DEPTH);
        drive(0, 1'b1, 1'b1, 1'b0, 9'h055);
        drive(1, 1'b1, 1'b1, 1'b0, 9'h055);
        tick();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("full simul count m%0d", m), 64'(cnt_o[m]), 64'(DEPTH - 1));
            chk($sformatf("full simul wrerr m%0d", m), 64'(werr_o[m]), 64'(1));
        end
        goto_level(0, 0);
        drive(0, 1'b1, 1'b1, 1'b0, 9'h066);
        drive(1, 1'b1, 1'b1, 1'b0, 9'h066);
        tick();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("empty simul count m%0d", m), 64'(cnt_o[m]), 64'(1));
            chk($sformatf("empty simul rderr m%0d", m), 64'(rerr_o[m]), 64'(1));
        end
        idle();
        tick();

        // Wrap-around: random traffic held between 100 and 400 words.
        goto_level(250, 250);
        ops = 0;
        for (int k = 0; k < 8000 && ops < 3 * DEPTH; k++) begin
            for (int m = 0; m < 2; m++) begin
                w0 = ($urandom_range(0, 1) == 1) && (mq[m].size() < 400);
                r0 = ($urandom_range(0, 1) == 1) && (mq[m].size() > 100);
                drive(m, w0, r0, 1'b0, 9'($urandom));
                if (m == 0) ops = ops + int'(w0) + int'(r0);
            end
            tick();
        end
        chk("wrap ops done", 64'(ops >= 3 * DEPTH), 64'(1));

        // Flush at 200 with a concurrent write.
        goto_level(200, 200);
        drive(0, 1'b1, 1'b0, 1'b1, 9'h0AB);
        drive(1, 1'b1, 1'b0, 1'b1, 9'h0AB);
        tick();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("clr count m%0d", m), 64'(cnt_o[m]),   64'(0));
            chk($sformatf("clr empty m%0d", m), 64'(empty_o[m]), 64'(1));
            chk($sformatf("clr dout m%0d", m),  64'(dout_o[m]),  64'(0));
            chk($sformatf("clr wrerr m%0d", m), 64'(werr_o[m]),  64'(0));
        end
        idle();

        // Asynchronous reset mid-cycle at count 300.
        goto_level(300, 300);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("arst count m%0d", m),  64'(cnt_o[m]),   64'(0));
            chk($sformatf("arst full m%0d", m),   64'(full_o[m]),  64'(0));
            chk($sformatf("arst empty m%0d", m),  64'(empty_o[m]), 64'(1));
            chk($sformatf("arst afull m%0d", m),  64'(af_o[m]),    64'(0));
            chk($sformatf("arst aempty m%0d", m), 64'(ae_o[m]),    64'(1));
            chk($sformatf("arst dout m%0d", m),   64'(dout_o[m]),  64'(0));
            chk($sformatf("arst wrerr m%0d", m),  64'(werr_o[m]),  64'(0));
            chk($sformatf("arst rderr m%0d", m),  64'(rerr_o[m]),  64'(0));
        end
        @(posedge clk);
        #3;
        rstn = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 9'h12C);
        drive(1, 1'b1, 1'b0, 1'b0, 9'h12C);
        tick();
        idle();
        tick();
        drive(0, 1'b0, 1'b1, 1'b0, 9'h000);
        drive(1, 1'b0, 1'b1, 1'b0, 9'h000);
        tick();
        chk("post-reset std dout", 64'(dout_o[0]), 64'(9'h12C));
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
